// File: rtl/calc2_port_responder.sv
// calc2 single-port responder: two-cycle request capture, add/sub/shift, tagged response after LATENCY cycles.
// Optional macro CALC2_SHIFT_OVF_EN: shifts that drop a 1 bit respond with error.
module calc2_port_responder #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'b01;
  localparam logic [1:0] RESP_ERR = 2'b10;

  generate
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $fatal(1, "calc2_port_responder: LATENCY must be in 1..8");
    end
    if (DEPTH < (LATENCY + 2) / 2) begin : g_bad_depth
      $fatal(1, "calc2_port_responder: DEPTH must be at least ceil((LATENCY+1)/2)");
    end
  endgenerate

  typedef enum logic {IDLE, OP2} state_t;

  state_t      state, state_nxt;
  logic        capture_en, alloc_en;

  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [1:0]  tag_q;
  logic [3:0]  mask;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_own;
  logic [2:0]       ent_cnt  [DEPTH];
  logic [1:0]       ent_resp [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [1:0]       ent_tag  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          head_fire;

  logic [32:0] sum;
  logic [4:0]  sh;
  logic [31:0] shl_res, shr_res;
  logic        collide, calc_ok;
  logic [31:0] calc_data;
  logic [1:0]  new_resp;
  logic [31:0] new_data;

  always_ff @(posedge c_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture_en = 1'b0;
    alloc_en   = 1'b0;
    case (state)
      IDLE: begin
        if (req_cmd_in != 4'd0) begin
          capture_en = 1'b1;
          state_nxt  = OP2;
        end
      end
      OP2: begin
        alloc_en  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result is formed from the captured operand 1 and the live operand 2 in the OP2 cycle.
  always_comb begin
    sum       = {1'b0, op1_q} + {1'b0, req_data_in};
    sh        = req_data_in[4:0];
    shl_res   = op1_q << sh;
    shr_res   = op1_q >> sh;
    collide   = mask[tag_q];
    calc_ok   = 1'b0;
    calc_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        calc_ok   = ~sum[32];
        calc_data = sum[31:0];
      end
      CMD_SUB: begin
        calc_ok   = (req_data_in <= op1_q);
        calc_data = op1_q - req_data_in;
      end
      CMD_SHL: begin
`ifdef CALC2_SHIFT_OVF_EN
        calc_ok = ((shl_res >> sh) == op1_q);
`else
        calc_ok = 1'b1;
`endif
        calc_data = shl_res;
      end
      CMD_SHR: begin
`ifdef CALC2_SHIFT_OVF_EN
        calc_ok = ((shr_res << sh) == op1_q);
`else
        calc_ok = 1'b1;
`endif
        calc_data = shr_res;
      end
      default: begin
        calc_ok   = 1'b0;
        calc_data = '0;
      end
    endcase
    if (calc_ok && !collide) begin
      new_resp = RESP_OK;
      new_data = calc_data;
    end else begin
      new_resp = RESP_ERR;
      new_data = '0;
    end
  end

  always_comb begin
    wr_nxt    = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    rd_nxt    = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    head_fire = ent_valid[rd_ptr] && (ent_cnt[rd_ptr] == 3'd0);
  end

  // Only the entry that set a mask bit may clear it, so a collided
  // request never releases the tag of the original outstanding one.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cmd_q     <= '0;
      op1_q     <= '0;
      tag_q     <= '0;
      mask      <= '0;
      ent_valid <= '0;
      ent_own   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_resp  <= '0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;

      if (capture_en) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
        tag_q <= req_tag_in;
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_valid[PW'(i)] && ent_cnt[PW'(i)] != 3'd0)
          ent_cnt[PW'(i)] <= ent_cnt[PW'(i)] - 3'd1;
      end

      if (head_fire) begin
        out_resp          <= ent_resp[rd_ptr];
        out_data          <= ent_data[rd_ptr];
        out_tag           <= ent_tag[rd_ptr];
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_nxt;
        if (ent_own[rd_ptr]) mask[ent_tag[rd_ptr]] <= 1'b0;
      end

      if (alloc_en) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_own[wr_ptr]   <= ~collide;
        ent_cnt[wr_ptr]   <= 3'(LATENCY - 1);
        ent_resp[wr_ptr]  <= new_resp;
        ent_data[wr_ptr]  <= new_data;
        ent_tag[wr_ptr]   <= tag_q;
        wr_ptr            <= wr_nxt;
        if (!collide) mask[tag_q] <= 1'b1;
      end
    end
  end

endmodule
